// File: rtl/vr_arb_pkg.sv
// Shared types and constants for the valid/ready packet arbiters.
package vr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of the mid-packet hole counter; holds any hole timeout up to 255.
    localparam int HOLE_CNT_W = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping with a true modulo so non-power-of-two request counts never alias.
module rr_picker #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             found_o
);

    localparam logic [ID_W:0] N_WRAP = (ID_W + 1)'(N_REQ);

    always_comb begin : pick
        logic [ID_W:0] cand;
        // NOTE: every output gets a default first; a path that skips an assignment would infer a latch.
        cand    = '0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_i} + (ID_W + 1)'(k);
            if (cand >= N_WRAP) begin
                cand = cand - N_WRAP;
            end
            if (!found_o && req_i[cand[ID_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vr_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one valid/ready sink among N_REQ
// requesters, with a mid-packet hole watchdog that forces the grant free.
module vr_pkt_arbiter
    import vr_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int HOLE_TO = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [$clog2(N_REQ)-1:0]  gnt_id,
    output logic                      busy,
    output logic                      err_hole
);

    localparam int                    ID_W     = $clog2(N_REQ);
    localparam logic [HOLE_CNT_W-1:0] HOLE_LIM = HOLE_CNT_W'(HOLE_TO);
    localparam logic [ID_W-1:0]       LAST_ID  = ID_W'(N_REQ - 1);

    arb_state_t              state_q, state_d;
    logic [ID_W-1:0]         gnt_q, gnt_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [HOLE_CNT_W-1:0]   hole_q, hole_d;
    logic                    err_q, err_d;

    logic [ID_W-1:0]         pick_idx;
    logic                    pick_found;
    logic [ID_W-1:0]         ptr_after;
    logic [DATA_W-1:0]       data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Pointer for the next arbitration once the current owner lets go.
    assign ptr_after = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hole_d    = hole_q;
        err_d     = err_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = data_arr[gnt_q];
        req_ready = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                out_valid        = req_valid[gnt_q];
                out_last         = req_last[gnt_q];
                req_ready[gnt_q] = out_ready;
                if (req_valid[gnt_q]) begin
                    // Stalled by the sink: hold everything, the hole counter only tracks a silent owner.
                    if (out_ready) begin
                        hole_d = '0;
                        if (req_last[gnt_q]) begin
                            state_d = IDLE;
                            ptr_d   = ptr_after;
                        end
                    end
                end else if (hole_q + 1'b1 == HOLE_LIM) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    ptr_d   = ptr_after;
                    hole_d  = '0;
                end else begin
                    hole_d = hole_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            hole_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hole_q  <= hole_d;
            err_q   <= err_d;
        end
    end

    assign busy     = (state_q == GRANT);
    assign gnt_id   = gnt_q;
    assign err_hole = err_q;

endmodule

// File: doc/vr_pkt_arbiter.md
Name: vr_pkt_arbiter

Overview:
- Packet-level round-robin arbiter sharing one valid/ready sink (the ready-throttling DUT datapath) among N_REQ requesters.
- One requester is granted per packet; the grant is held until that packet's last beat is accepted.
- Passes valid/data/last through combinationally once granted and honours sink backpressure.
- Includes a hole watchdog so a stalled requester cannot lock the sink indefinitely.

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- DATA_W, 8: payload width.
- HOLE_TO, 15: consecutive valid-low cycles allowed mid-packet before forced release, 1..255.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  N_REQ  per-requester valid
- req_last  input  N_REQ  per-requester last-beat flag
- req_data  input  N_REQ*DATA_W  flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  per-requester ready
- out_valid  output  1  valid to sink
- out_last  output  1  last to sink
- out_data  output  DATA_W  payload to sink
- out_ready  input  1  sink ready
- gnt_id  output  $clog2(N_REQ)  index of current/last granted requester
- busy  output  1  state == GRANT
- err_hole  output  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset values: state IDLE, rr_ptr 0, gnt_id 0, hole_cnt 0, err_hole 0. Therefore out_valid 0, req_ready all 0, busy 0.
- States: IDLE and GRANT.
- IDLE, no arbitration this cycle if any(req_valid) is 0; stay in IDLE.
- IDLE, when any(req_valid) is 1:
  - Pick the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Register gnt_id<=i and go to GRANT.
  - Arbitration latency is exactly 1 cycle; no data passes in IDLE.
- GRANT outputs:
  - out_valid = req_valid[gnt_id]; out_data and out_last come from gnt_id.
  - req_ready[gnt_id] = out_ready; all other req_ready bits are 0.
- Beat handshake: out_valid && out_ready.
- Handshake with out_last=1: go to IDLE, rr_ptr<=(gnt_id+1) mod N_REQ, hole_cnt<=0. This gives 1 bubble cycle between packets.
- Handshake with out_last=0: stay in GRANT, hole_cnt<=0.
- GRANT with req_valid[gnt_id]=0: hole_cnt++.
  - When hole_cnt reaches HOLE_TO: err_hole<=1, go to IDLE, rr_ptr<=gnt_id+1.
  - The truncated packet is not patched; no last beat is emitted.
- GRANT with valid high and out_ready low: hold everything and do not count.
- The grant never changes while out_valid is high and not yet accepted (valid/data stable under backpressure).
- Single-beat packet (valid && last): legal; GRANT lasts 1 cycle if ready is high.
- rr_ptr wraps from N_REQ-1 to 0. Non-power-of-2 N_REQ uses a true modulo, never an index >= N_REQ.
- Simultaneous requests: only the RR-selected requester sees ready; the others hold their data.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is discarded downstream.
- Requester valid changes in IDLE do not affect outputs until the grant is registered.

Decomposition:
- Package vr_arb_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - localparam for the hole counter width (8)
- Sub-module rr_picker: combinational request vector + pointer -> index and found flag, parameterised by N_REQ. It is reused by later multi-sink arbiters.

Test Plan:
- Reset then req_valid=4'b0000 for 10 cycles -> out_valid 0, busy 0, gnt_id 0, all req_ready 0.
- req 0 sends a 3-beat packet (0x11, 0x12, 0x13 last) with out_ready=1 -> grant cycle 1; beats on cycles 2-4; IDLE cycle 5; rr_ptr=1.
- req_valid=4'b1111, each sends 1-beat packets continuously -> grant order 0,1,2,3,0; each packet is followed by one idle cycle; no starvation.
- Granted req 2 beat 0xA5 with out_ready low for 7 cycles -> out_data held at 0xA5, out_valid held at 1, gnt_id=2; accepted on the ready cycle; hole_cnt stays 0.
- Granted req 1 drops valid after beat 1 for 15 cycles, HOLE_TO=15 -> err_hole=1, return to IDLE, next grant goes to req 2 if pending; err_hole stays 1 until rst_n low.
- rst_n pulsed low mid-packet on req 3 -> outputs reset asynchronously; after release, arbitration restarts from req 0.
